// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions (abcdefg, active-high) used by both the encoder and the scan capture.
// The table lives here once so encoder and decoder can never disagree.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_0     = 7'h7E;
  localparam seg_t SEG_1     = 7'h30;
  localparam seg_t SEG_2     = 7'h6D;
  localparam seg_t SEG_3     = 7'h79;
  localparam seg_t SEG_4     = 7'h33;
  localparam seg_t SEG_5     = 7'h5B;
  localparam seg_t SEG_6     = 7'h5F;
  localparam seg_t SEG_7     = 7'h70;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h7B;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h1F;
  localparam seg_t SEG_C     = 7'h4E;
  localparam seg_t SEG_D     = 7'h3D;
  localparam seg_t SEG_E     = 7'h4F;
  localparam seg_t SEG_F     = 7'h47;
  localparam seg_t SEG_BLANK = 7'h00;

  function automatic seg_t seg7_encode(input nibble_t n);
    seg_t s;
    case (n)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the segment encoder: exact pattern match back to a hex nibble.
// Unknown patterns (including blank) return nibble 0 with match low.
module seg7_decode
  import seg7_pkg::*;
(
  input  seg_t    seg_in,
  output nibble_t nibble,
  output logic    match
);

  always_comb begin
    nibble = 4'h0;
    match  = 1'b1;
    case (seg_in)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      default: begin
        nibble = 4'h0;
        match  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Readback of a multiplexed 7-segment bus: synchronise, sample on a divided tick, debounce each
// digit, and present the assembled word on a valid/ready interface.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NDIGITS    = 4,
  parameter int SAMPLE_DIV = 16,
  parameter int STABLE_CNT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             seg_in,
  input  logic [NDIGITS-1:0]     dig_sel,
  output logic [4*NDIGITS-1:0]   word_out,
  output logic [NDIGITS-1:0]     word_err,
  output logic                   word_valid,
  input  logic                   word_ready
);

  localparam int                 DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
  localparam logic [3:0]         STABLE_N = 4'(STABLE_CNT);
  localparam logic [NDIGITS-1:0] SEL_ONE  = NDIGITS'(1);

  seg_t               seg_s1_q, seg_s2_q;
  logic [NDIGITS-1:0] sel_s1_q, sel_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= SEG_BLANK;
      seg_s2_q <= SEG_BLANK;
      sel_s1_q <= '0;
      sel_s2_q <= '0;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      sel_s1_q <= dig_sel;
      sel_s2_q <= sel_s1_q;
    end
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + DIV_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

  // A zero or multi-hot select is a transition artefact of the scanner, never a real sample.
  logic sel_onehot;
  assign sel_onehot = (sel_s2_q != '0) && ((sel_s2_q & (sel_s2_q - SEL_ONE)) == '0);

  nibble_t dec_nibble;
  logic    dec_match;

  seg7_decode u_decode (
    .seg_in (seg_s2_q),
    .nibble (dec_nibble),
    .match  (dec_match)
  );

  logic [NDIGITS-1:0] commit;

  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
    seg_t       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hit;
    logic       commit_bit;

    assign hit        = tick & sel_onehot & sel_s2_q[gi];
    assign commit[gi] = commit_bit;

    // Commit fires only on the step into STABLE_N, so a held pattern is reported once.
    always_comb begin
      last_d     = last_q;
      cnt_d      = cnt_q;
      commit_bit = 1'b0;
      if (hit) begin
        if (seg_s2_q == last_q) begin
          if (cnt_q < STABLE_N) begin
            cnt_d      = cnt_q + 4'd1;
            commit_bit = ((cnt_q + 4'd1) == STABLE_N);
          end
        end else begin
          last_d     = seg_s2_q;
          cnt_d      = 4'd1;
          commit_bit = (STABLE_N == 4'd1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        last_q <= SEG_BLANK;
        cnt_q  <= 4'd0;
      end else begin
        last_q <= last_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  logic [4*NDIGITS-1:0] shadow_q, shadow_d;
  logic [NDIGITS-1:0]   serr_q, serr_d;
  logic [NDIGITS-1:0]   upd_q, upd_d;
  logic [4*NDIGITS-1:0] word_out_q, word_out_d;
  logic [NDIGITS-1:0]   word_err_q, word_err_d;
  logic                 valid_q, valid_d;
  logic                 load;

  assign load = (upd_q == '1) && (!valid_q || word_ready);

  // Load copies the pre-commit shadow; a same-cycle commit lands afterwards and keeps its upd bit.
  always_comb begin
    shadow_d   = shadow_q;
    serr_d     = serr_q;
    upd_d      = upd_q;
    word_out_d = word_out_q;
    word_err_d = word_err_q;
    valid_d    = valid_q;
    if (load) begin
      word_out_d = shadow_q;
      word_err_d = serr_q;
      valid_d    = 1'b1;
      upd_d      = '0;
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
    for (int i = 0; i < NDIGITS; i++) begin
      if (commit[i]) begin
        shadow_d[4*i +: 4] = dec_nibble;
        serr_d[i]          = ~dec_match;
        upd_d[i]           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      serr_q     <= '0;
      upd_q      <= '0;
      word_out_q <= '0;
      word_err_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      serr_q     <= serr_d;
      upd_q      <= upd_d;
      word_out_q <= word_out_d;
      word_err_q <= word_err_d;
      valid_q    <= valid_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_err   = word_err_q;
  assign word_valid = valid_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: slot-level digit model feeding an expected-word queue,
// one compare process on every clock, plus literal expectations per scenario.
module tb_seg7_scan_capture;

  localparam int SDIV = 4;
  localparam int SCNT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h00;
  logic [3:0]  dig_sel = 4'h0;
  logic        word_ready = 1'b1;
  logic [15:0] word_out;
  logic [3:0]  word_err;
  logic        word_valid;

  always #5 clk = ~clk;

  seg7_scan_capture #(
    .NDIGITS    (4),
    .SAMPLE_DIV (SDIV),
    .STABLE_CNT (SCNT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_sel    (dig_sel),
    .word_out   (word_out),
    .word_err   (word_err),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int n_checks = 0;
  int n_errors = 0;

  // model state: per-digit last pattern / stability count, pending word and its filled mask
  logic [6:0]  m_last [4];
  int          m_cnt  [4];
  logic [3:0]  m_nib  [4];
  logic        m_err  [4];
  logic [3:0]  m_upd;
  logic [19:0] exp_q [$];
  logic [19:0] acc_log [$];
  logic        done6;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("check %s ok: %h", name, act);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_last[i] = 7'h00; m_cnt[i] = 0; m_nib[i] = 4'h0; m_err[i] = 1'b0;
    end
    m_upd = 4'h0;
    exp_q.delete();
  endfunction

  function automatic void model_sample(input logic [3:0] sel, input logic [6:0] p);
    int  idx;
    bit  commit;
    bit  hit;
    logic [3:0] nib;
    if ($countones(sel) != 1) return;
    idx = 0;
    for (int k = 0; k < 4; k++) if (sel[k]) idx = k;
    commit = 0;
    if (p == m_last[idx]) begin
      if (m_cnt[idx] < SCNT) begin
        m_cnt[idx]++;
        commit = (m_cnt[idx] == SCNT);
      end
    end else begin
      m_last[idx] = p;
      m_cnt[idx]  = 1;
      commit = (SCNT == 1);
    end
    if (commit) begin
      hit = 0; nib = 4'h0;
      for (int k = 0; k < 16; k++) if (tbl[k] == p) begin hit = 1; nib = 4'(k); end
      m_nib[idx] = nib;
      m_err[idx] = !hit;
      m_upd[idx] = 1'b1;
      if (m_upd == 4'hF) begin
        exp_q.push_back({m_err[3], m_err[2], m_err[1], m_err[0],
                         m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
        m_upd = 4'h0;
      end
    end
  endfunction

  task automatic slot(input logic [3:0] sel, input logic [6:0] p);
    seg_in  = p;
    dig_sel = sel;
    model_sample(sel, p);
    repeat (SDIV) @(negedge clk);
  endtask

  task automatic round_pat(input logic [27:0] pats, input int n);
    for (int r = 0; r < n; r++)
      for (int i = 0; i < 4; i++) slot(4'(1 << i), pats[7*i +: 7]);
  endtask

  function automatic logic [27:0] enc_word(input logic [15:0] w);
    logic [27:0] p;
    logic [3:0]  nib;
    for (int i = 0; i < 4; i++) begin
      nib = w[4*i +: 4];
      p[7*i +: 7] = tbl[nib];
    end
    return p;
  endfunction

  task automatic do_reset();
    model_reset();
    acc_log.delete();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dig_sel = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic end_check(input string name, input int exp_acc);
    repeat (4) slot(4'h0, 7'h00);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_valid_idle"}, {31'd0, word_valid}, 32'd0);
    chk({name, "_word_count"}, 32'(acc_log.size()), 32'(exp_acc));
  endtask

  // compare process: every cycle, 1 time unit after the rising edge
  initial begin
    logic        lv;
    logic [15:0] lo;
    logic [3:0]  le;
    logic [19:0] e;
    lv = 1'b0; lo = 16'h0; le = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("reset_outputs", {11'd0, word_valid, word_err, word_out}, 32'd0);
        lv = 1'b0;
      end else begin
        if (lv && word_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word: got %h expected no word (t=%0t)", {le, lo}, $time);
          end else begin
            e = exp_q.pop_front();
            chk("word_accept", {12'd0, le, lo}, {12'd0, e});
          end
          acc_log.push_back({le, lo});
        end else if (lv) begin
          chk("stall_hold", {11'd0, word_valid, word_err, word_out}, {11'd0, 1'b1, le, lo});
        end
        lv = word_valid; lo = word_out; le = word_err;
      end
    end
  end

  initial begin
    logic [27:0] pats;
    logic [15:0] w6;
    done6 = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset mid-capture discards partial digits
    do_reset();
    for (int r = 0; r < 2; r++) begin
      slot(4'h2, tbl[1]); slot(4'h4, tbl[2]); slot(4'h8, tbl[3]);
    end
    seg_in = tbl[1]; dig_sel = 4'h2;
    repeat (2) @(negedge clk);
    do_reset();
    chk("t1_after_reset", {11'd0, word_valid, word_err, word_out}, 32'd0);
    for (int r = 0; r < 3; r++) begin
      slot(4'h0, 7'h00); slot(4'h2, tbl[1]); slot(4'h4, tbl[2]); slot(4'h8, tbl[3]);
    end
    repeat (2) slot(4'h0, 7'h00);
    chk("t1_no_partial_word", {31'd0, word_valid}, 32'd0);
    round_pat(enc_word(16'h3210), 3);
    end_check("t1", 1);
    if (acc_log.size() > 0) chk("t1_word", {12'd0, acc_log[0]}, {12'd0, 4'h0, 16'h3210});

    // 2: static "12AF", one word only
    do_reset();
    round_pat(enc_word(16'h12AF), 6);
    end_check("t2", 1);
    if (acc_log.size() > 0) chk("t2_word", {12'd0, acc_log[0]}, {12'd0, 4'h0, 16'h12AF});

    // 3: invalid pattern on dig0 and blank on dig2
    do_reset();
    round_pat({7'h30, 7'h00, 7'h77, 7'h01}, 4);
    end_check("t3", 1);
    if (acc_log.size() > 0) chk("t3_word", {12'd0, acc_log[0]}, {12'd0, 4'b0101, 16'h10A0});

    // 4a: dig1 toggling never settles
    do_reset();
    for (int r = 0; r < 6; r++) begin
      pats = enc_word(16'h3210);
      pats[13:7] = (r % 2 == 1) ? tbl[2] : tbl[1];
      round_pat(pats, 1);
    end
    end_check("t4a", 0);

    // 4b: zero/multi-hot selects carrying a foreign pattern must be ignored
    do_reset();
    for (int r = 0; r < 2; r++) begin
      round_pat(enc_word(16'h4567), 1);
      slot(4'b0011, 7'h7F); slot(4'b1100, 7'h7F); slot(4'b0000, 7'h7F); slot(4'b1111, 7'h7F);
    end
    repeat (3) slot(4'h0, 7'h00);
    chk("t4b_not_yet", {31'd0, word_valid}, 32'd0);
    round_pat(enc_word(16'h4567), 1);
    end_check("t4b", 1);
    if (acc_log.size() > 0) chk("t4b_word", {12'd0, acc_log[0]}, {12'd0, 4'h0, 16'h4567});

    // 5: back-pressure keeps the first word while the second is captured
    do_reset();
    word_ready = 1'b0;
    round_pat(enc_word(16'h1234), 4);
    repeat (2) slot(4'h0, 7'h00);
    chk("t5_first_held", {15'd0, word_valid, word_out}, {15'd0, 1'b1, 16'h1234});
    round_pat(enc_word(16'h5678), 4);
    repeat (2) slot(4'h0, 7'h00);
    chk("t5_still_held", {15'd0, word_valid, word_out}, {15'd0, 1'b1, 16'h1234});
    word_ready = 1'b1;
    end_check("t5", 2);
    if (acc_log.size() > 1) begin
      chk("t5_word0", {12'd0, acc_log[0]}, {12'd0, 4'h0, 16'h1234});
      chk("t5_word1", {12'd0, acc_log[1]}, {12'd0, 4'h0, 16'h5678});
    end

    // 6: all table entries round-trip with random ready
    do_reset();
    fork
      begin
        for (int e = 0; e < 16; e++) begin
          for (int i = 0; i < 4; i++) w6[4*i +: 4] = 4'((e + i) % 16);
          round_pat(enc_word(w6), 4);
        end
        done6 = 1'b1;
      end
      begin
        int  z;
        logic r;
        z = 0;
        while (!done6) begin
          @(negedge clk);
          r = 1'($urandom_range(0, 1));
          if (z >= 3) r = 1'b1;
          z = r ? 0 : z + 1;
          word_ready = r;
        end
      end
    join
    word_ready = 1'b1;
    end_check("t6", 16);
    if (acc_log.size() > 0) chk("t6_word0", {12'd0, acc_log[0]}, {12'd0, 4'h0, 16'h3210});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
